// File: rtl/floo_axi_rsp_unpacker.sv
// Purpose: steer FlooRsp link flits to buffered AXI B / R outputs, track R bursts, count illegal flits.
// Latency: one cycle minimum from accepted flit to output valid; no combinational fall-through.
// Backpressure: link ready follows the fullness of the FIFO the flit targets; illegal flits are always sunk.

// Purpose: generic first-in-first-out buffer with registered storage.
// Latency: pushed data is visible at the head one cycle later.
// Backpressure: o_full blocks pushes even when a pop happens in the same cycle.
module floo_rsp_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic [DataWidth-1:0] i_dat,
  input  logic                 i_pop,
  output logic [DataWidth-1:0] o_dat,
  output logic                 o_vld,
  output logic                 o_full
);

  localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth  = $clog2(Depth + 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0]  r_cnt;
  logic                 w_push;
  logic                 w_pop;

  function automatic logic [AddrWidth-1:0] ptr_next(input logic [AddrWidth-1:0] p);
    return (p == AddrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full = (r_cnt == CntWidth'(Depth));
  assign o_vld  = (r_cnt != '0);
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && o_vld;
  // Head is masked to zero while empty so outputs read 0 when not valid.
  assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset because the occupancy count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

module floo_axi_rsp_unpacker #(
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned BWidth       = 8,
  parameter int unsigned RWidth       = 63,
  parameter int unsigned FifoDepth    = 2,
  parameter int unsigned CntWidth     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flit_valid_i,
  output logic                    flit_ready_o,
  input  logic [2:0]              flit_ch_i,
  input  logic                    flit_last_i,
  input  logic [PayloadWidth-1:0] flit_payload_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [BWidth-1:0]       b_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [RWidth-1:0]       r_o,
  output logic                    r_last_o,
  output logic                    r_in_burst_o,
  output logic [CntWidth-1:0]     beat_cnt_o,
  output logic                    err_o,
  output logic [CntWidth-1:0]     err_cnt_o
);

  if (BWidth >= PayloadWidth) begin : g_bwidth_chk
    $error("floo_axi_rsp_unpacker: BWidth must be smaller than PayloadWidth");
  end
  if (RWidth >= PayloadWidth) begin : g_rwidth_chk
    $error("floo_axi_rsp_unpacker: RWidth must be smaller than PayloadWidth");
  end
  if (FifoDepth < 1) begin : g_depth_chk
    $error("floo_axi_rsp_unpacker: FifoDepth must be at least 1");
  end

  localparam logic [2:0] AxiB = 3'd3;
  localparam logic [2:0] AxiR = 3'd4;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } burst_state_e;

  logic                w_is_b;
  logic                w_is_r;
  logic                w_acc;
  logic                w_b_full;
  logic                w_r_full;
  logic [RWidth:0]     w_r_dat;
  logic                w_unused_rsvd;
  burst_state_e        r_state;
  burst_state_e        w_state_nxt;
  logic [CntWidth-1:0] r_beat_cnt;
  logic [CntWidth-1:0] w_beat_cnt_nxt;
  logic                r_err;
  logic [CntWidth-1:0] r_err_cnt;

  // Reserved padding above each channel's width is deliberately discarded.
  assign w_unused_rsvd = ^flit_payload_i;

  assign w_is_b = (flit_ch_i == AxiB);
  assign w_is_r = (flit_ch_i == AxiR);

  // Ready depends only on the channel and target FIFO fullness, never on valid.
  assign flit_ready_o = w_is_b ? !w_b_full : (w_is_r ? !w_r_full : 1'b1);
  assign w_acc        = flit_valid_i && flit_ready_o;

  floo_rsp_fifo #(
    .DataWidth (BWidth),
    .Depth     (FifoDepth)
  ) u_b_fifo (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_push (w_acc && w_is_b),
    .i_dat  (flit_payload_i[BWidth-1:0]),
    .i_pop  (b_ready_i),
    .o_dat  (b_o),
    .o_vld  (b_valid_o),
    .o_full (w_b_full)
  );

  floo_rsp_fifo #(
    .DataWidth (RWidth + 1),
    .Depth     (FifoDepth)
  ) u_r_fifo (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_push (w_acc && w_is_r),
    .i_dat  ({flit_last_i, flit_payload_i[RWidth-1:0]}),
    .i_pop  (r_ready_i),
    .o_dat  (w_r_dat),
    .o_vld  (r_valid_o),
    .o_full (w_r_full)
  );

  assign r_o      = w_r_dat[RWidth-1:0];
  assign r_last_o = w_r_dat[RWidth];

  // Burst state and beat counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Burst framing: advances only on accepted R flits; a last beat always closes the burst.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    if (w_acc && w_is_r) begin
      if (flit_last_i) begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_state_nxt    = ST_BURST;
            w_beat_cnt_nxt = CntWidth'(1);
          end
          ST_BURST: begin
            w_state_nxt    = ST_BURST;
            w_beat_cnt_nxt = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + 1'b1;
          end
          default: begin
            w_state_nxt    = ST_IDLE;
            w_beat_cnt_nxt = '0;
          end
        endcase
      end
    end
  end

  assign r_in_burst_o = (r_state == ST_BURST);
  assign beat_cnt_o   = r_beat_cnt;

  // Sticky error flag and saturating count of accepted illegal-channel flits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_acc && !w_is_b && !w_is_r) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;

endmodule
